// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: EX->MEM register, data-memory bus handshake and load/store lane formatting
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_valid,
    input  logic [31:0] EX_C,
    input  logic [31:0] EX_rD2,
    input  logic [4:0]  EX_wR,
    input  logic        EX_RFWr,
    input  logic [1:0]  EX_WDSel,
    input  logic        EX_MemRd,
    input  logic        EX_MemWr,
    input  logic [2:0]  EX_MemSize,
    output logic        MEM_valid,
    output logic [31:0] MEM_C,
    output logic [31:0] MEM_wR,
    output logic        MEM_RFWr,
    output logic [1:0]  MEM_WDSel,
    output logic [31:0] MEM_rd_,
    output logic        MEM_misalign,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_wstrb,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_accept;
    logic        w_capture_rd;
    logic        w_wait;
    logic        w_ex_mem;
    logic        w_ex_aligned;

    logic        r_valid;
    logic [31:0] r_c;
    logic [31:0] r_rd2;
    logic [4:0]  r_wr;
    logic        r_rfwr;
    logic [1:0]  r_wdsel;
    logic        r_memwr;
    logic [2:0]  r_size;
    logic        r_misalign;
    logic [31:0] r_rd;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;

    // Width comes from MemSize[1:0] alone: 00 byte, 01 half, 1x word (loads and stores alike)
    assign w_ex_mem = EX_MemRd | EX_MemWr;
    always_comb begin
        case (EX_MemSize[1:0])
            2'b00:   w_ex_aligned = 1'b1;
            2'b01:   w_ex_aligned = ~EX_C[0];
            default: w_ex_aligned = (EX_C[1:0] == 2'b00);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture_rd = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_accept     = 1'b1;
                w_state_next = (EX_valid && w_ex_mem && w_ex_aligned) ? WAIT : IDLE;
            end
            WAIT: begin
                if (dm_ack) begin
                    w_state_next = DONE;
                    w_capture_rd = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_c        <= '0;
            r_rd2      <= '0;
            r_wr       <= '0;
            r_rfwr     <= 1'b0;
            r_wdsel    <= '0;
            r_memwr    <= 1'b0;
            r_size     <= '0;
            r_misalign <= 1'b0;
            r_rd       <= '0;
        end else if (w_accept) begin
            r_c     <= EX_C;
            r_rd2   <= EX_rD2;
            r_wr    <= EX_wR;
            r_size  <= EX_MemSize;
            if (!EX_valid) begin
                r_valid    <= 1'b0;
                r_rfwr     <= 1'b0;
                r_wdsel    <= '0;
                r_memwr    <= 1'b0;
                r_misalign <= 1'b0;
            end else if (w_ex_mem && !w_ex_aligned) begin
                // Trapping op: keep it visible but suppress writeback and the bus access
                r_valid    <= 1'b1;
                r_rfwr     <= 1'b0;
                r_wdsel    <= EX_WDSel;
                r_memwr    <= 1'b0;
                r_misalign <= 1'b1;
            end else begin
                r_valid    <= 1'b1;
                r_rfwr     <= EX_RFWr;
                r_wdsel    <= EX_WDSel;
                r_memwr    <= EX_MemWr;
                r_misalign <= 1'b0;
            end
        end else if (w_capture_rd) begin
            r_rd <= r_memwr ? 32'd0 : w_load_ext;
        end
    end

    always_comb begin
        case (r_c[1:0])
            2'b00:   w_byte = dm_rdata[7:0];
            2'b01:   w_byte = dm_rdata[15:8];
            2'b10:   w_byte = dm_rdata[23:16];
            default: w_byte = dm_rdata[31:24];
        endcase
        w_half = r_c[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (r_size[1:0])
            2'b00:   w_load_ext = {{24{~r_size[2] & w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = {{16{~r_size[2] & w_half[15]}}, w_half};
            default: w_load_ext = dm_rdata;
        endcase
    end

    always_comb begin
        case (r_size[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << r_c[1:0];
                w_wdata = {4{r_rd2[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << r_c[1:0];
                w_wdata = {2{r_rd2[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = r_rd2;
            end
        endcase
    end

    // Bus signals are gated by WAIT so an asynchronous reset drops them immediately
    assign w_wait       = (r_state == WAIT);
    assign stall        = w_wait;
    assign dm_req       = w_wait;
    assign dm_we        = w_wait & r_memwr;
    assign dm_addr      = w_wait ? {r_c[31:2], 2'b00} : 32'd0;
    assign dm_wdata     = (w_wait & r_memwr) ? w_wdata : 32'd0;
    assign dm_wstrb     = (w_wait & r_memwr) ? w_wstrb : 4'd0;

    assign MEM_valid    = r_valid;
    assign MEM_C        = r_c;
    assign MEM_wR       = {27'd0, r_wr};
    assign MEM_RFWr     = r_rfwr;
    assign MEM_WDSel    = r_wdsel;
    assign MEM_rd_      = r_rd;
    assign MEM_misalign = r_misalign;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_valid;
    logic [31:0] EX_C;
    logic [31:0] EX_rD2;
    logic [4:0]  EX_wR;
    logic        EX_RFWr;
    logic [1:0]  EX_WDSel;
    logic        EX_MemRd;
    logic        EX_MemWr;
    logic [2:0]  EX_MemSize;
    logic        MEM_valid;
    logic [31:0] MEM_C;
    logic [31:0] MEM_wR;
    logic        MEM_RFWr;
    logic [1:0]  MEM_WDSel;
    logic [31:0] MEM_rd_;
    logic        MEM_misalign;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    int checks = 0;
    int errors = 0;

    mem_access dut (
        .clk(clk), .rst(rst),
        .EX_valid(EX_valid), .EX_C(EX_C), .EX_rD2(EX_rD2), .EX_wR(EX_wR),
        .EX_RFWr(EX_RFWr), .EX_WDSel(EX_WDSel), .EX_MemRd(EX_MemRd),
        .EX_MemWr(EX_MemWr), .EX_MemSize(EX_MemSize),
        .MEM_valid(MEM_valid), .MEM_C(MEM_C), .MEM_wR(MEM_wR), .MEM_RFWr(MEM_RFWr),
        .MEM_WDSel(MEM_WDSel), .MEM_rd_(MEM_rd_), .MEM_misalign(MEM_misalign),
        .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [31:0] c, input logic [31:0] rd2,
                         input logic [4:0] wr, input logic rfwr, input logic [1:0] wdsel,
                         input logic mrd, input logic mwr, input logic [2:0] size);
        EX_valid = v; EX_C = c; EX_rD2 = rd2; EX_wR = wr; EX_RFWr = rfwr;
        EX_WDSel = wdsel; EX_MemRd = mrd; EX_MemWr = mwr; EX_MemSize = size;
    endtask

    task automatic bubble();
        issue(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic test_reset();
        checks++;
        if ({MEM_valid, MEM_RFWr, MEM_WDSel, MEM_misalign, stall, dm_req, dm_we, dm_wstrb} !== 12'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 0",
                     {MEM_valid, MEM_RFWr, MEM_WDSel, MEM_misalign, stall, dm_req, dm_we, dm_wstrb});
        end
        checks++;
        if ({MEM_C, MEM_wR, MEM_rd_, dm_addr, dm_wdata} !== 160'd0) begin
            errors++;
            $display("FAIL reset_data C=%h wR=%h rd=%h addr=%h wdata=%h expected 0",
                     MEM_C, MEM_wR, MEM_rd_, dm_addr, dm_wdata);
        end
    endtask

    task automatic test_lw_wait();
        issue(1'b1, 32'h100, 32'd0, 5'd3, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010);
        tick();
        bubble();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                dm_ack = 1'b1;
                dm_rdata = 32'hDEADBEEF;
            end
            checks++;
            if (dm_req !== 1'b1 || stall !== 1'b1 || dm_addr !== 32'h100 || dm_we !== 1'b0) begin
                errors++;
                $display("FAIL lw_wait cyc%0d req=%b stall=%b addr=%h we=%b expected 1 1 00000100 0",
                         i, dm_req, stall, dm_addr, dm_we);
            end
            tick();
        end
        dm_ack = 1'b0;
        checks++;
        if (dm_req !== 1'b0 || stall !== 1'b0 || MEM_rd_ !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_done req=%b stall=%b rd=%h expected 0 0 deadbeef", dm_req, stall, MEM_rd_);
        end
        checks++;
        if (MEM_valid !== 1'b1 || MEM_wR !== 32'd3 || MEM_WDSel !== 2'b01 || MEM_RFWr !== 1'b1) begin
            errors++;
            $display("FAIL lw_regs valid=%b wR=%h wdsel=%b rfwr=%b expected 1 3 01 1",
                     MEM_valid, MEM_wR, MEM_WDSel, MEM_RFWr);
        end
        tick();
        checks++;
        if (MEM_valid !== 1'b0 || stall !== 1'b0 || MEM_rd_ !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_after valid=%b stall=%b rd=%h expected 0 0 deadbeef", MEM_valid, stall, MEM_rd_);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  sizes [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] addrs [3] = '{32'h103, 32'h103, 32'h102};
        logic [31:0] exps  [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, addrs[i], 32'd0, 5'd4, 1'b1, 2'b01, 1'b1, 1'b0, sizes[i]);
            tick();
            bubble();
            dm_ack = 1'b1;
            dm_rdata = 32'h80FFFFFF;
            tick();
            dm_ack = 1'b0;
            checks++;
            if (MEM_rd_ !== exps[i]) begin
                errors++;
                $display("FAIL load_ext size=%b rd=%h expected %h", sizes[i], MEM_rd_, exps[i]);
            end
            tick();
        end
    endtask

    task automatic test_store();
        issue(1'b1, 32'h202, 32'h1234ABCD, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b001);
        tick();
        bubble();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dm_addr !== 32'h200 || dm_wstrb !== 4'b1100 || dm_wdata !== 32'hABCDABCD || dm_we !== 1'b1) begin
                errors++;
                $display("FAIL sh_bus cyc%0d addr=%h strb=%b wdata=%h we=%b expected 00000200 1100 abcdabcd 1",
                         i, dm_addr, dm_wstrb, dm_wdata, dm_we);
            end
            if (i == 1) dm_ack = 1'b1;
            tick();
        end
        dm_ack = 1'b0;
        checks++;
        if (MEM_rd_ !== 32'd0 || dm_req !== 1'b0) begin
            errors++;
            $display("FAIL sh_done rd=%h req=%b expected 0 0", MEM_rd_, dm_req);
        end
        tick();
        issue(1'b1, 32'h201, 32'h000000AB, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b100);
        tick();
        bubble();
        checks++;
        if (dm_addr !== 32'h200 || dm_wstrb !== 4'b0010 || dm_wdata !== 32'hABABABAB) begin
            errors++;
            $display("FAIL sb_bus addr=%h strb=%b wdata=%h expected 00000200 0010 abababab",
                     dm_addr, dm_wstrb, dm_wdata);
        end
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        tick();
        issue(1'b1, 32'h204, 32'hCAFEF00D, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b010);
        tick();
        bubble();
        checks++;
        if (dm_addr !== 32'h204 || dm_wstrb !== 4'b1111 || dm_wdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL sw_bus addr=%h strb=%b wdata=%h expected 00000204 1111 cafef00d",
                     dm_addr, dm_wstrb, dm_wdata);
        end
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        tick();
    endtask

    task automatic test_misalign();
        issue(1'b1, 32'h101, 32'd0, 5'd7, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010);
        tick();
        bubble();
        checks++;
        if (dm_req !== 1'b0 || MEM_misalign !== 1'b1 || MEM_RFWr !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL misalign req=%b mis=%b rfwr=%b stall=%b expected 0 1 0 0",
                     dm_req, MEM_misalign, MEM_RFWr, stall);
        end
        tick();
        checks++;
        if (MEM_misalign !== 1'b0 || stall !== 1'b0 || dm_req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_clear mis=%b stall=%b req=%b expected 0 0 0", MEM_misalign, stall, dm_req);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            issue(1'b1, 32'h1000 + i, 32'd0, 5'(i + 10), 1'b1, 2'b00, 1'b0, 1'b0, 3'b000);
            tick();
            checks++;
            if (MEM_C !== 32'h1000 + i || MEM_wR !== 32'(i + 10) || MEM_valid !== 1'b1 || stall !== 1'b0) begin
                errors++;
                $display("FAIL b2b op%0d C=%h wR=%h valid=%b stall=%b expected %h %h 1 0",
                         i, MEM_C, MEM_wR, MEM_valid, stall, 32'h1000 + i, 32'(i + 10));
            end
        end
        bubble();
        tick();
        checks++;
        if (MEM_valid !== 1'b0 || MEM_RFWr !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble valid=%b rfwr=%b stall=%b expected 0 0 0", MEM_valid, MEM_RFWr, stall);
        end
    endtask

    task automatic test_reset_wait();
        issue(1'b1, 32'h300, 32'd0, 5'd9, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010);
        tick();
        bubble();
        checks++;
        if (dm_req !== 1'b1) begin
            errors++;
            $display("FAIL rstwait_enter req=%b expected 1", dm_req);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (dm_req !== 1'b0 || stall !== 1'b0 || dm_addr !== 32'd0 || MEM_valid !== 1'b0 || MEM_C !== 32'd0) begin
            errors++;
            $display("FAIL rstwait_async req=%b stall=%b addr=%h valid=%b C=%h expected 0 0 0 0 0",
                     dm_req, stall, dm_addr, MEM_valid, MEM_C);
        end
        #1 rst = 1'b0;
        dm_ack = 1'b1;
        dm_rdata = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dm_req !== 1'b0 || stall !== 1'b0 || MEM_rd_ !== 32'd0) begin
                errors++;
                $display("FAIL rstwait_ack cyc%0d req=%b stall=%b rd=%h expected 0 0 0", i, dm_req, stall, MEM_rd_);
            end
        end
        dm_ack = 1'b0;
        issue(1'b1, 32'h55, 32'd0, 5'd2, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000);
        tick();
        checks++;
        if (MEM_C !== 32'h55 || MEM_valid !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL resume_alu C=%h valid=%b stall=%b expected 00000055 1 0", MEM_C, MEM_valid, stall);
        end
        issue(1'b1, 32'h304, 32'd0, 5'd2, 1'b1, 2'b01, 1'b1, 1'b0, 3'b010);
        tick();
        bubble();
        dm_ack = 1'b1;
        dm_rdata = 32'h0BADF00D;
        tick();
        dm_ack = 1'b0;
        checks++;
        if (MEM_rd_ !== 32'h0BADF00D || stall !== 1'b0) begin
            errors++;
            $display("FAIL resume_load rd=%h stall=%b expected 0badf00d 0", MEM_rd_, stall);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        dm_ack = 1'b0;
        dm_rdata = 32'd0;
        bubble();
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        test_lw_wait();
        test_load_ext();
        test_store();
        test_misalign();
        test_back_to_back();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
